// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard/sequencing logic:
//   state_e   - sequencer state (RUN / MC_WAIT / MEM_WAIT), 2-bit encoded
//   REG_ZERO  - architectural x0, never a real data dependence
//   ctrl_t    - the enable/flush bundle driven to the pipeline registers
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_flush;
    logic mc_start;
  } ctrl_t;

  // Free-flowing pipe: everything advances, nothing is squashed.
  localparam ctrl_t CTRL_FLOW = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
    idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, exmem_flush: 1'b0,
    memwb_flush: 1'b0, mc_start: 1'b0
  };

  // Held while reset is asserted: nothing advances, every stage holds a bubble.
  localparam ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
    idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b0, exmem_flush: 1'b1,
    memwb_flush: 1'b1, mc_start: 1'b0
  };

endpackage

// File: rtl/hazard_perf_counter.sv
// -----------------------------------------------------------------------------
// hazard_perf_counter
// Single saturating event counter (sticks at all-ones).
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears count
//   inc   - count this cycle
//   count - current value, W bits
// -----------------------------------------------------------------------------
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline sequencer for the 5-stage core. Produces PC / pipeline-register
// enables and flushes for load-use bubbles, taken-branch redirects, mul/div
// multi-cycle ops and data-memory wait states. Forwarding handles everything
// else; this block only stalls, squashes or freezes.
//
// Parameters:
//   MC_TIMEOUT - cycles in MC_WAIT before the sticky watchdog sets (>=2)
//   PERF_W     - performance counter width (HAZARD_PERF_EN builds only)
//
// Ports:
//   i_clk, i_rst_n              clock / asynchronous active-low reset
//   i_ifid_*                    source regs and kind of the ID instruction
//   i_idex_*                    rd / load / mul-div flags of the EX instruction
//   i_ex_branch_taken           EX resolved a redirect
//   i_mc_done                   mul/div result valid pulse
//   i_dmem_req, i_dmem_ready    data-memory access in MEM and its completion
//   o_pc_en .. o_memwb_flush    pipeline enables / bubble loads
//   o_mc_start                  one-cycle mul/div launch
//   o_mc_timeout                sticky mul/div watchdog
//   o_state                     registered sequencer state (debug)
//   o_perf_stall_cycles,
//   o_perf_flush_count          only when HAZARD_PERF_EN is defined
//
// Optional feature macro: HAZARD_PERF_EN (adds stall/redirect counters).
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W     = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_ifid_rs1,
  input  logic [4:0]  i_ifid_rs2,
  input  logic        i_ifid_uses_rs1,
  input  logic        i_ifid_uses_rs2,
  input  logic        i_ifid_is_store,
  input  logic [4:0]  i_idex_rd,
  input  logic        i_idex_mem_to_reg,
  input  logic        i_idex_multicycle,
  input  logic        i_ex_branch_taken,
  input  logic        i_mc_done,
  input  logic        i_dmem_req,
  input  logic        i_dmem_ready,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_ifid_flush,
  output logic        o_idex_en,
  output logic        o_idex_flush,
  output logic        o_exmem_en,
  output logic        o_exmem_flush,
  output logic        o_memwb_flush,
  output logic        o_mc_start,
  output logic        o_mc_timeout,
  output logic [1:0]  o_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] o_perf_stall_cycles,
  output logic [PERF_W-1:0] o_perf_flush_count
`endif
);

  localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mc_cnt_q;
  logic             mc_timeout_q;
  ctrl_t            ctrl;

  logic load_use;
  logic mem_hold;
  logic mc_hold;
  logic mc_issue;
  logic redirect;

  // Store data (rs2 of a store) is excluded: MEM-stage forwarding covers it.
  assign load_use = i_idex_mem_to_reg && (i_idex_rd != REG_ZERO) &&
                    ((i_ifid_uses_rs1 && (i_ifid_rs1 == i_idex_rd)) ||
                     (i_ifid_uses_rs2 && (i_ifid_rs2 == i_idex_rd) && !i_ifid_is_store));

  // A memory wait is entered only from RUN; in MC_WAIT EX/MEM holds bubbles,
  // so a stray i_dmem_req there is ignored.
  assign mem_hold = ((state_q == RUN) && i_dmem_req && !i_dmem_ready) ||
                    ((state_q == MEM_WAIT) && !i_dmem_ready);
  assign mc_hold  = (state_q == MC_WAIT) && !i_mc_done;
  // The MC_WAIT release cycle never relaunches the op still sitting in EX.
  assign mc_issue = !mem_hold && (state_q != MC_WAIT) && i_idex_multicycle;
  assign redirect = !mem_hold && !mc_hold && !mc_issue && i_ex_branch_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    state_d = RUN;
    if (mem_hold) begin
      state_d = MEM_WAIT;
    end else if (mc_hold || mc_issue) begin
      state_d = MC_WAIT;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: highest-priority hazard wins
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl = CTRL_FLOW;
    if (!i_rst_n) begin
      ctrl = CTRL_RESET;
    end else if (mem_hold) begin
      // Freeze everything up to EX/MEM; MEM/WB drains a bubble.
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_en    = 1'b0;
      ctrl.memwb_flush = 1'b1;
    end else if (mc_hold || mc_issue) begin
      // Mul/div occupies EX; bubbles flow into EX/MEM behind it.
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_flush = 1'b1;
      ctrl.mc_start    = mc_issue;
    end else if (redirect) begin
      // Both younger instructions are wrong-path, so any load-use is moot.
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_flush  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mul/div watchdog: counts MC_WAIT cycles, sets a sticky flag on the
  // MC_TIMEOUT-th one but keeps waiting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mc_cnt_q     <= '0;
      mc_timeout_q <= 1'b0;
    end else if (state_q == MC_WAIT) begin
      if (mc_cnt_q == CNT_LAST) begin
        mc_timeout_q <= 1'b1;
      end
      if (i_mc_done) begin
        mc_cnt_q <= '0;
      end else if (mc_cnt_q != CNT_LAST) begin
        mc_cnt_q <= mc_cnt_q + 1'b1;
      end
    end else begin
      mc_cnt_q <= '0;
    end
  end

  assign o_pc_en       = ctrl.pc_en;
  assign o_ifid_en     = ctrl.ifid_en;
  assign o_ifid_flush  = ctrl.ifid_flush;
  assign o_idex_en     = ctrl.idex_en;
  assign o_idex_flush  = ctrl.idex_flush;
  assign o_exmem_en    = ctrl.exmem_en;
  assign o_exmem_flush = ctrl.exmem_flush;
  assign o_memwb_flush = ctrl.memwb_flush;
  assign o_mc_start    = ctrl.mc_start;
  assign o_mc_timeout  = mc_timeout_q;
  assign o_state       = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_counter #(.W(PERF_W)) u_stall_counter (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (!ctrl.pc_en),
    .count (o_perf_stall_cycles)
  );

  hazard_perf_counter #(.W(PERF_W)) u_flush_counter (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (redirect),
    .count (o_perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed scenarios followed by random traffic, each cycle compared against
// an event-based reference model of the sequencer with MC_TIMEOUT = 4.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int TMO = 4;

  // Model modes (what the pipe is waiting on)
  localparam int M_RUN = 0;
  localparam int M_MC  = 1;
  localparam int M_MEM = 2;

  // Winning event for a cycle
  localparam int EV_NONE   = 0;
  localparam int EV_RESET  = 1;
  localparam int EV_MEM    = 2;
  localparam int EV_MCWAIT = 3;
  localparam int EV_MCGO   = 4;
  localparam int EV_REDIR  = 5;
  localparam int EV_LU     = 6;

  // Control pattern per event, bit order:
  // pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_flush mc_start
  logic [8:0] pattern [7];

  logic       i_clk, i_rst_n;
  logic [4:0] i_ifid_rs1, i_ifid_rs2, i_idex_rd;
  logic       i_ifid_uses_rs1, i_ifid_uses_rs2, i_ifid_is_store;
  logic       i_idex_mem_to_reg, i_idex_multicycle, i_ex_branch_taken;
  logic       i_mc_done, i_dmem_req, i_dmem_ready;
  logic       o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush;
  logic       o_exmem_en, o_exmem_flush, o_memwb_flush, o_mc_start, o_mc_timeout;
  logic [1:0] o_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_mode = M_RUN;
  int m_wait = 0;
  bit m_to   = 1'b0;
  int m_ev   = EV_NONE;

  hazard_control_unit #(.MC_TIMEOUT(TMO)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_ifid_rs1        (i_ifid_rs1),
    .i_ifid_rs2        (i_ifid_rs2),
    .i_ifid_uses_rs1   (i_ifid_uses_rs1),
    .i_ifid_uses_rs2   (i_ifid_uses_rs2),
    .i_ifid_is_store   (i_ifid_is_store),
    .i_idex_rd         (i_idex_rd),
    .i_idex_mem_to_reg (i_idex_mem_to_reg),
    .i_idex_multicycle (i_idex_multicycle),
    .i_ex_branch_taken (i_ex_branch_taken),
    .i_mc_done         (i_mc_done),
    .i_dmem_req        (i_dmem_req),
    .i_dmem_ready      (i_dmem_ready),
    .o_pc_en           (o_pc_en),
    .o_ifid_en         (o_ifid_en),
    .o_ifid_flush      (o_ifid_flush),
    .o_idex_en         (o_idex_en),
    .o_idex_flush      (o_idex_flush),
    .o_exmem_en        (o_exmem_en),
    .o_exmem_flush     (o_exmem_flush),
    .o_memwb_flush     (o_memwb_flush),
    .o_mc_start        (o_mc_start),
    .o_mc_timeout      (o_mc_timeout),
    .o_state           (o_state)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Which rule wins this cycle, judged from the model mode and current inputs.
  function automatic int pick_event();
    bit lu, allow_mc;
    lu = i_idex_mem_to_reg && (i_idex_rd != 5'd0) &&
         ((i_ifid_uses_rs1 && i_ifid_rs1 == i_idex_rd) ||
          (i_ifid_uses_rs2 && i_ifid_rs2 == i_idex_rd && !i_ifid_is_store));
    if (!i_rst_n) return EV_RESET;
    if (m_mode == M_MEM && !i_dmem_ready) return EV_MEM;
    if (m_mode == M_RUN && i_dmem_req && !i_dmem_ready) return EV_MEM;
    if (m_mode == M_MC && !i_mc_done) return EV_MCWAIT;
    allow_mc = (m_mode != M_MC);
    if (allow_mc && i_idex_multicycle) return EV_MCGO;
    if (i_ex_branch_taken) return EV_REDIR;
    if (lu) return EV_LU;
    return EV_NONE;
  endfunction

  task automatic check_cycle(input string tag);
    logic [11:0] exp, obs;
    logic [1:0]  st;
    m_ev = pick_event();
    st   = 2'(m_mode);
    exp  = {pattern[m_ev], m_to, st};
    obs  = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_flush,
            o_exmem_en, o_exmem_flush, o_memwb_flush, o_mc_start,
            o_mc_timeout, o_state};
    chk(tag, obs, exp);
  endtask

  // Clock edge seen by the model: watchdog bookkeeping, then mode change.
  task automatic advance();
    if (m_mode == M_MC) begin
      m_wait++;
      if (m_wait >= TMO) m_to = 1'b1;
    end else begin
      m_wait = 0;
    end
    case (m_ev)
      EV_MEM:            m_mode = M_MEM;
      EV_MCWAIT, EV_MCGO: m_mode = M_MC;
      default:           m_mode = M_RUN;
    endcase
    if (m_mode != M_MC) m_wait = 0;
  endtask

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic st,
                      input logic [4:0] rd, input logic ld, input logic mc,
                      input logic br, input logic done, input logic req,
                      input logic rdy, input string tag);
    i_ifid_rs1 = rs1;  i_ifid_rs2 = rs2;
    i_ifid_uses_rs1 = u1;  i_ifid_uses_rs2 = u2;  i_ifid_is_store = st;
    i_idex_rd = rd;  i_idex_mem_to_reg = ld;  i_idex_multicycle = mc;
    i_ex_branch_taken = br;  i_mc_done = done;
    i_dmem_req = req;  i_dmem_ready = rdy;
    #2;
    check_cycle(tag);
    @(posedge i_clk);
    advance();
    #1;
  endtask

  task automatic idle(input string tag);
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Reset asserted mid-cycle: outputs must react without waiting for a clock.
  task automatic do_reset(input string tag);
    i_rst_n = 1'b0;
    m_mode = M_RUN;
    m_wait = 0;
    m_to   = 1'b0;
    #2;
    check_cycle(tag);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    pattern[EV_NONE]   = 9'b110101000;
    pattern[EV_RESET]  = 9'b001010110;
    pattern[EV_MEM]    = 9'b000000010;
    pattern[EV_MCWAIT] = 9'b000001100;
    pattern[EV_MCGO]   = 9'b000001101;
    pattern[EV_REDIR]  = 9'b111111000;
    pattern[EV_LU]     = 9'b000111000;

    i_ifid_rs1 = '0;  i_ifid_rs2 = '0;  i_idex_rd = '0;
    i_ifid_uses_rs1 = 0;  i_ifid_uses_rs2 = 0;  i_ifid_is_store = 0;
    i_idex_mem_to_reg = 0;  i_idex_multicycle = 0;  i_ex_branch_taken = 0;
    i_mc_done = 0;  i_dmem_req = 0;  i_dmem_ready = 1;
    i_rst_n = 1'b1;
    #1;
    do_reset("reset_init");

    // Load-use on rs1, then release; rd = x0 never stalls
    step(5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0, 0, 0, 1, "lu_rs1");
    idle("lu_after");
    step(5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 0, 0, 0, 0, 1, "lu_x0");

    // Store data dependence is forwarded; address dependence stalls
    step(5'd6, 5'd5, 1, 1, 1, 5'd5, 1, 0, 0, 0, 0, 1, "lu_store_data");
    step(5'd5, 5'd5, 1, 1, 1, 5'd5, 1, 0, 0, 0, 0, 1, "lu_store_addr");
    step(5'd7, 5'd5, 1, 1, 0, 5'd5, 1, 0, 0, 0, 0, 1, "lu_rs2");

    // Redirect overrides load-use
    step(5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 1, 0, 0, 1, "br_over_lu");

    // Mul launched, done arrives 4 cycles after start, no relaunch on release
    step(5'd0, 5'd0, 0, 0, 0, 5'd3, 0, 1, 0, 0, 0, 1, "mc_start");
    step(5'd0, 5'd0, 0, 0, 0, 5'd3, 0, 1, 0, 0, 0, 1, "mc_wait1");
    step(5'd0, 5'd0, 0, 0, 0, 5'd3, 0, 1, 0, 0, 1, 0, "mc_wait2_dmem_ign");
    step(5'd0, 5'd0, 0, 0, 0, 5'd3, 0, 1, 0, 0, 0, 1, "mc_wait3");
    step(5'd0, 5'd0, 0, 0, 0, 5'd3, 0, 1, 0, 1, 0, 1, "mc_release");
    idle("mc_after");
    do_reset("reset_after_mc");

    // Memory wait for 3 cycles, release, then reset mid-wait
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, "mem_enter");
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, "mem_wait1");
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, "mem_wait2");
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 1, 1, "mem_release_mc");
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 1, "mc_fast_done");
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, "mem_enter2");
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1, 0, "mem_wait3");
    do_reset("reset_mid_mem");
    chk("state_after_reset", {10'd0, o_state}, 12'd0);

    // Watchdog: done withheld well past the limit, flag stays after done
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 1, "tmo_start");
    for (int i = 0; i < 6; i++) step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0, 1, "tmo_wait");
    chk("timeout_set", {11'd0, o_mc_timeout}, 12'd1);
    step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 0, 1, "tmo_release_br");
    idle("tmo_after");
    chk("timeout_sticky", {11'd0, o_mc_timeout}, 12'd1);
    do_reset("reset_clears_tmo");
    chk("timeout_cleared", {11'd0, o_mc_timeout}, 12'd0);

    // Random traffic with small register numbers to provoke dependences
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_reset");
      end else begin
        step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
